// File: rtl/apb_uart_bridge.sv
// APB slave bridging the bus to the UART TX/RX cores with byte FIFOs in both directions.
// Zero-wait APB: TXDATA/RXDATA/STATUS/CTRL; sticky overrun/frame flags and a combined irq.
module apb_uart_bridge #(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int RX_THRESH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  pAdd,
  input  logic [31:0] pwData,
  input  logic        psel,
  input  logic        pen,
  input  logic        pwr,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  txData,
  output logic        txStart,
  input  logic        txDone,
  input  logic        busy,
  input  logic [7:0]  rxData,
  input  logic        rxDone,
  input  logic        err_in,
  output logic        tx_en,
  output logic        rx_en,
  output logic        err_out,
  output logic        irq
);
  localparam int TXP_W = $clog2(TX_DEPTH);
  localparam int RXP_W = $clog2(RX_DEPTH);
  localparam int TXC_W = TXP_W + 1;
  localparam int RXC_W = RXP_W + 1;
  localparam logic [TXC_W-1:0] TX_FULL_CNT = TXC_W'(TX_DEPTH);
  localparam logic [RXC_W-1:0] RX_FULL_CNT = RXC_W'(RX_DEPTH);
  localparam logic [RXC_W-1:0] RX_TH_CNT   = RXC_W'(RX_THRESH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} tx_state_t;
  tx_state_t r_state, w_state_next;

  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [TXP_W-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [RXP_W-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [TXC_W-1:0] r_tx_count;
  logic [RXC_W-1:0] r_rx_count;
  logic [7:0]       r_tx_data;
  logic             r_tx_en, r_rx_en, r_rx_ie, r_tx_ie;
  logic             r_overrun, r_frame_err;
  logic             r_txdone_d, r_rxdone_d, r_err_d;

  logic w_access, w_wr, w_rd;
  logic w_sel_tx, w_sel_rx, w_sel_st, w_sel_ct;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_evt;
  logic w_tx_flush, w_rx_flush, w_ctrl_wr, w_st_wr;
  logic w_ovr_set, w_fe_set, w_txdone_rise, w_tx_active, w_err;
  logic [31:0] w_status;
  logic w_unused_bits;

  assign w_access = psel & pen;
  assign w_wr     = w_access & pwr;
  assign w_rd     = w_access & ~pwr;
  assign w_sel_tx = (pAdd[3:2] == 2'd0);
  assign w_sel_rx = (pAdd[3:2] == 2'd1);
  assign w_sel_st = (pAdd[3:2] == 2'd2);
  assign w_sel_ct = (pAdd[3:2] == 2'd3);
  assign w_unused_bits = ^{pAdd[1:0], pwData[31:8]};

  assign w_tx_full  = (r_tx_count == TX_FULL_CNT);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == RX_FULL_CNT);
  assign w_rx_empty = (r_rx_count == '0);

  assign w_txdone_rise = txDone & ~r_txdone_d;
  assign w_fe_set      = err_in & ~r_err_d;
  assign w_rx_evt      = r_rx_en & rxDone & ~r_rxdone_d;

  // A push into a full FIFO is only accepted when the same FIFO pops this cycle.
  assign w_tx_pop  = (r_state == S_LOAD) & ~w_tx_empty;
  assign w_tx_push = w_wr & w_sel_tx & (~w_tx_full | w_tx_pop);
  assign w_rx_pop  = w_rd & w_sel_rx & ~w_rx_empty;
  assign w_rx_push = w_rx_evt & (~w_rx_full | w_rx_pop);
  assign w_ovr_set = w_rx_evt & w_rx_full & ~w_rx_pop;

  assign w_ctrl_wr  = w_wr & w_sel_ct;
  assign w_st_wr    = w_wr & w_sel_st;
  assign w_tx_flush = w_ctrl_wr & pwData[2];
  assign w_rx_flush = w_ctrl_wr & pwData[3];

  assign w_err = (w_sel_tx & (~pwr | (w_tx_full & ~w_tx_pop))) |
                 (w_sel_rx & (pwr | w_rx_empty));
  assign pready  = w_access;
  assign pslverr = w_access & w_err;

  assign w_tx_active = (r_state != S_IDLE);
  assign w_status = {8'd0, 8'(r_rx_count), 8'(r_tx_count), 1'b0, w_tx_active,
                     r_frame_err, r_overrun, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (pAdd[3:2])
        2'd1:    if (!w_rx_empty) prdata = {24'd0, r_rx_mem[r_rx_rd_ptr]};
        2'd2:    prdata = w_status;
        2'd3:    prdata = {26'd0, r_tx_ie, r_rx_ie, 2'b00, r_rx_en, r_tx_en};
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push && !w_tx_flush) r_tx_mem[r_tx_wr_ptr] <= pwData[7:0];
    if (w_rx_push && !w_rx_flush) r_rx_mem[r_rx_wr_ptr] <= rxData;
  end

  // Flush wins over a same-cycle push or pop; stored bytes are left in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else if (w_tx_flush) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + TXP_W'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + TXP_W'(1);
      if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + TXC_W'(1);
      else if (!w_tx_push && w_tx_pop) r_tx_count <= r_tx_count - TXC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else if (w_rx_flush) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + RXP_W'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + RXP_W'(1);
      if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + RXC_W'(1);
      else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - RXC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_tx_pop) r_tx_data <= r_tx_mem[r_tx_rd_ptr];
    end
  end

  // A flush landing on the IDLE->LOAD edge leaves LOAD with nothing to send.
  always_comb begin
    w_state_next = r_state;
    txStart      = 1'b0;
    case (r_state)
      S_IDLE:  if (r_tx_en && !w_tx_empty && !busy) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = w_tx_empty ? S_IDLE : S_START;
      S_START: begin
        txStart      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT:  if (w_txdone_rise) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_en     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_rx_ie     <= 1'b0;
      r_tx_ie     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_txdone_d  <= 1'b0;
      r_rxdone_d  <= 1'b0;
      r_err_d     <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_tx_en <= pwData[0];
        r_rx_en <= pwData[1];
        r_rx_ie <= pwData[4];
        r_tx_ie <= pwData[5];
      end
      r_overrun   <= w_ovr_set | (r_overrun & ~(w_st_wr & pwData[4]));
      r_frame_err <= w_fe_set | (r_frame_err & ~(w_st_wr & pwData[5]));
      r_txdone_d  <= txDone;
      r_rxdone_d  <= rxDone;
      r_err_d     <= err_in;
    end
  end

  assign txData  = r_tx_data;
  assign tx_en   = r_tx_en;
  assign rx_en   = r_rx_en;
  assign err_out = r_frame_err;
  assign irq = (r_rx_ie & (r_rx_count >= RX_TH_CNT)) | (r_tx_ie & w_tx_empty & ~w_tx_active) |
               r_overrun | r_frame_err;
endmodule

// File: tb/tb_apb_uart_bridge.sv
// Self-checking bench for apb_uart_bridge: directed scenarios plus a randomized
// register/FIFO sequence checked against queue-based expectations.
`timescale 1ns/1ps
module tb_apb_uart_bridge;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pAdd = '0;
  logic [31:0] pwData = '0;
  logic        psel = 1'b0, pen = 1'b0, pwr = 1'b0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  txData;
  logic        txStart;
  logic        txDone = 1'b0, busy = 1'b0;
  logic [7:0]  rxData = '0;
  logic        rxDone = 1'b0, err_in = 1'b0;
  logic        tx_en, rx_en, err_out, irq;

  int total = 0;
  int bad = 0;

  apb_uart_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .RX_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .pAdd(pAdd), .pwData(pwData), .psel(psel), .pen(pen),
    .pwr(pwr), .prdata(prdata), .pready(pready), .pslverr(pslverr), .txData(txData),
    .txStart(txStart), .txDone(txDone), .busy(busy), .rxData(rxData), .rxDone(rxDone),
    .err_in(err_in), .tx_en(tx_en), .rx_en(rx_en), .err_out(err_out), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  // STATUS word as the register map defines it, from queue sizes and flags.
  function automatic logic [31:0] exp_status(int txn, int rxn, bit ovr, bit fe, bit act);
    int s;
    s = (rxn << 16) + (txn << 8) + (act ? 64 : 0) + (fe ? 32 : 0) + (ovr ? 16 : 0) +
        (rxn == 0 ? 8 : 0) + (rxn == DEPTH ? 4 : 0) + (txn == 0 ? 2 : 0) + (txn == DEPTH ? 1 : 0);
    return 32'(s);
  endfunction

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, input logic with_err,
                           input logic with_rx, input logic [7:0] rx_byte, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwr = 1'b1; pAdd = addr; pwData = data;
    @(posedge clk); #1;
    pen = 1'b1;
    if (with_err) err_in = 1'b1;
    if (with_rx) begin rxData = rx_byte; rxDone = 1'b1; end
    @(negedge clk);
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0; pwr = 1'b0; err_in = 1'b0; rxDone = 1'b0;
    $display("apb wr addr=%h data=%h err=%0b", addr, data, err);
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwr = 1'b0; pAdd = addr;
    @(posedge clk); #1;
    pen = 1'b1;
    @(negedge clk);
    data = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0;
    $display("apb rd addr=%h data=%h err=%0b", addr, data, err);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk); #1 rxData = b; rxDone = 1'b1;
    @(posedge clk); #1 rxDone = 1'b0;
    $display("uart rx byte=%h", b);
  endtask

  task automatic tx_done_pulse();
    @(posedge clk); #1 txDone = 1'b1;
    @(posedge clk); #1 txDone = 1'b0;
  endtask

  // n = negedges until txStart seen (0 = timed out)
  task automatic wait_start(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (txStart === 1'b1) begin n = k; break; end
    end
    $display("uart tx start after %0d cycles byte=%h", n, txData);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({prdata, pslverr, pready} !== 34'd0) begin bad++;
      $display("FAIL reset_apb: got prdata=%h pslverr=%b pready=%b, want all 0", prdata, pslverr, pready); end
    total++; if ({txData, txStart, tx_en, rx_en, err_out, irq} !== 13'd0) begin bad++;
      $display("FAIL reset_uart: got txData=%h txStart=%b tx_en=%b rx_en=%b err_out=%b irq=%b, want 0",
               txData, txStart, tx_en, rx_en, err_out, irq); end
    psel = 1'b1; pen = 1'b1; pAdd = 4'h8; #1;
    total++; if (pready !== 1'b1) begin bad++;
      $display("FAIL reset_pready: got %b want 1", pready); end
    psel = 1'b0; pen = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    apb_read(4'h8, d, e);
    total++; if (d !== 32'h0000_000A || e !== 1'b0) begin bad++;
      $display("FAIL reset_status: got %h err=%b want 0000000a err=0", d, e); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] d; logic e; int n; int highs;
    logic [7:0] bytes [3];
    bytes[0] = 8'h55; bytes[1] = 8'hAA; bytes[2] = 8'($urandom);
    apb_write(4'hC, 32'h1, 1'b0, 1'b0, 8'h0, e);
    for (int i = 0; i < 2; i++) begin
      apb_write(4'h0, {24'd0, bytes[i]}, 1'b0, 1'b0, 8'h0, e);
      wait_start(n);
      total++; if (n !== 3) begin bad++;
        $display("FAIL tx_latency: got %0d cycles want 3", n); end
      total++; if (txData !== bytes[i]) begin bad++;
        $display("FAIL tx_data: got %h want %h", txData, bytes[i]); end
      @(negedge clk);
      total++; if (txStart !== 1'b0) begin bad++;
        $display("FAIL tx_start_width: got %b want 0", txStart); end
      tx_done_pulse();
    end
    busy = 1'b1;
    apb_write(4'h0, {24'd0, bytes[2]}, 1'b0, 1'b0, 8'h0, e);
    highs = 0;
    repeat (6) begin @(negedge clk); if (txStart) highs++; end
    total++; if (highs !== 0) begin bad++;
      $display("FAIL tx_busy_hold: got %0d starts want 0", highs); end
    busy = 1'b0;
    wait_start(n);
    total++; if (n == 0 || txData !== bytes[2]) begin bad++;
      $display("FAIL tx_after_busy: got n=%0d data=%h want start with %h", n, txData, bytes[2]); end
    tx_done_pulse();
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 0, 0, 0, 0)) begin bad++;
      $display("FAIL tx_final_status: got %h want %h", d, exp_status(0, 0, 0, 0, 0)); end
    apb_write(4'hC, 32'h0, 1'b0, 1'b0, 8'h0, e);
  endtask

  task automatic test_tx_full();
    logic [31:0] d; logic e; int n; int highs;
    logic [7:0] q [$];
    logic [7:0] b;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      apb_write(4'h0, {24'd0, b}, 1'b0, 1'b0, 8'h0, e);
      if (i < DEPTH) q.push_back(b);
      total++; if (e !== (i == DEPTH)) begin bad++;
        $display("FAIL tx_fill_err[%0d]: got %b want %b", i, e, (i == DEPTH)); end
    end
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(DEPTH, 0, 0, 0, 0)) begin bad++;
      $display("FAIL tx_full_status: got %h want %h", d, exp_status(DEPTH, 0, 0, 0, 0)); end
    apb_write(4'hC, 32'h1, 1'b0, 1'b0, 8'h0, e);
    while (q.size() > 0) begin
      b = q.pop_front();
      wait_start(n);
      total++; if (n == 0 || txData !== b) begin bad++;
        $display("FAIL tx_drain: got n=%0d data=%h want %h", n, txData, b); end
      tx_done_pulse();
    end
    highs = 0;
    repeat (8) begin @(negedge clk); if (txStart) highs++; end
    total++; if (highs !== 0) begin bad++;
      $display("FAIL tx_dropped_byte: got %0d extra starts want 0", highs); end
    apb_write(4'hC, 32'h0, 1'b0, 1'b0, 8'h0, e);
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'h2, 1'b0, 1'b0, 8'h0, e);
    for (int i = 0; i <= DEPTH; i++) rx_pulse(8'(i));
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, DEPTH, 1, 0, 0)) begin bad++;
      $display("FAIL rx_overrun_status: got %h want %h", d, exp_status(0, DEPTH, 1, 0, 0)); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++;
      $display("FAIL rx_overrun_irq: got %b want 1", irq); end
    @(posedge clk); #1 psel = 1'b1; pen = 1'b0; pwr = 1'b0; pAdd = 4'h4;
    @(negedge clk);
    total++; if (prdata !== 32'd0 || pready !== 1'b0 || pslverr !== 1'b0) begin bad++;
      $display("FAIL setup_phase: got prdata=%h pready=%b pslverr=%b want 0", prdata, pready, pslverr); end
    @(posedge clk); #1 psel = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      apb_read(4'h4, d, e);
      if (i < DEPTH) begin
        total++; if (d !== 32'(i) || e !== 1'b0) begin bad++;
          $display("FAIL rx_read[%0d]: got %h err=%b want %h err=0", i, d, e, i); end
      end else begin
        total++; if (d !== 32'd0 || e !== 1'b1) begin bad++;
          $display("FAIL rx_read_empty: got %h err=%b want 0 err=1", d, e); end
      end
    end
    apb_write(4'h8, 32'h10, 1'b0, 1'b0, 8'h0, e);
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 0, 0, 0, 0)) begin bad++;
      $display("FAIL rx_w1c_overrun: got %h want %h", d, exp_status(0, 0, 0, 0, 0)); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++;
      $display("FAIL rx_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'h0, 1'b0, 1'b0, 8'h0, e);
    @(posedge clk); #1 err_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (err_out !== 1'b1 || irq !== 1'b1) begin bad++;
      $display("FAIL frame_set: got err_out=%b irq=%b want 1 1", err_out, irq); end
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 0, 0, 1, 0)) begin bad++;
      $display("FAIL frame_status: got %h want %h", d, exp_status(0, 0, 0, 1, 0)); end
    apb_write(4'h8, 32'h20, 1'b0, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (err_out !== 1'b0) begin bad++;
      $display("FAIL frame_w1c_level_held: got %b want 0", err_out); end
    apb_write(4'h8, 32'h20, 1'b1, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (err_out !== 1'b1) begin bad++;
      $display("FAIL frame_set_beats_w1c: got %b want 1", err_out); end
    apb_write(4'h8, 32'h20, 1'b0, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (err_out !== 1'b0 || irq !== 1'b0) begin bad++;
      $display("FAIL frame_clear: got err_out=%b irq=%b want 0 0", err_out, irq); end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic e; int n;
    apb_write(4'hC, 32'h2, 1'b0, 1'b0, 8'h0, e);
    repeat (5) rx_pulse(8'($urandom));
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 5, 0, 0, 0)) begin bad++;
      $display("FAIL flush_pre_status: got %h want %h", d, exp_status(0, 5, 0, 0, 0)); end
    apb_write(4'hC, 32'h8, 1'b0, 1'b1, 8'($urandom), e);
    apb_read(4'hC, d, e);
    total++; if (d !== 32'd0) begin bad++;
      $display("FAIL flush_ctrl_readback: got %h want 0", d); end
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 0, 0, 0, 0)) begin bad++;
      $display("FAIL rx_flush_status: got %h want %h", d, exp_status(0, 0, 0, 0, 0)); end
    repeat (3) apb_write(4'h0, 32'($urandom), 1'b0, 1'b0, 8'h0, e);
    apb_write(4'hC, 32'h4, 1'b0, 1'b0, 8'h0, e);
    apb_read(4'h8, d, e);
    total++; if (d !== exp_status(0, 0, 0, 0, 0)) begin bad++;
      $display("FAIL tx_flush_status: got %h want %h", d, exp_status(0, 0, 0, 0, 0)); end
    apb_write(4'h0, 32'h3C, 1'b0, 1'b0, 8'h0, e);
    apb_write(4'hC, 32'h1, 1'b0, 1'b0, 8'h0, e);
    wait_start(n);
    total++; if (n == 0 || txData !== 8'h3C) begin bad++;
      $display("FAIL tx_after_flush: got n=%0d data=%h want 3c", n, txData); end
    tx_done_pulse();
    apb_write(4'hC, 32'h0, 1'b0, 1'b0, 8'h0, e);
  endtask

  task automatic test_irq();
    logic [31:0] d; logic e;
    apb_write(4'hC, 32'h12, 1'b0, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_idle: got %b want 0", irq); end
    rx_pulse(8'($urandom));
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx_thresh: got %b want 1", irq); end
    apb_read(4'h4, d, e);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_rx_drained: got %b want 0", irq); end
    apb_write(4'hC, 32'h20, 1'b0, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    apb_write(4'hC, 32'h0, 1'b0, 1'b0, 8'h0, e);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off: got %b want 0", irq); end
  endtask

  // Random mix of pushes, deliveries, pops, status reads, W1C and flushes (tx engine off).
  task automatic test_random();
    logic [31:0] d, exp; logic e, exp_e; int n; bit ovr;
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] b;
    ovr = 0;
    apb_write(4'hC, 32'h2, 1'b0, 1'b0, 8'h0, e);
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          b = 8'($urandom);
          exp_e = (txq.size() == DEPTH);
          apb_write(4'h0, {24'($urandom), b}, 1'b0, 1'b0, 8'h0, e);
          if (!exp_e) txq.push_back(b);
          total++; if (e !== exp_e) begin bad++;
            $display("FAIL rand_tx_push: got err=%b want %b", e, exp_e); end
        end
        3, 4, 5: begin
          b = 8'($urandom);
          rx_pulse(b);
          if (rxq.size() == DEPTH) ovr = 1; else rxq.push_back(b);
        end
        6, 7: begin
          exp_e = (rxq.size() == 0);
          exp = exp_e ? 32'd0 : {24'd0, rxq[0]};
          apb_read(4'h4 | 4'($urandom_range(0, 3)), d, e);
          if (!exp_e) void'(rxq.pop_front());
          total++; if (d !== exp || e !== exp_e) begin bad++;
            $display("FAIL rand_rx_pop: got %h err=%b want %h err=%b", d, e, exp, exp_e); end
        end
        8: begin
          if ($urandom_range(0, 1) == 1) begin
            apb_write(4'h8, 32'h10, 1'b0, 1'b0, 8'h0, e);
            ovr = 0;
          end else begin
            n = $urandom_range(0, 3);
            apb_write(4'hC, 32'h2 | 32'(n << 2), 1'b0, 1'b0, 8'h0, e);
            if (n[0]) txq.delete();
            if (n[1]) rxq.delete();
          end
        end
        default: begin
          exp = exp_status(txq.size(), rxq.size(), ovr, 0, 0);
          apb_read(4'h8, d, e);
          total++; if (d !== exp || e !== 1'b0) begin bad++;
            $display("FAIL rand_status: got %h err=%b want %h err=0", d, e, exp); end
        end
      endcase
    end
    apb_write(4'hC, 32'h1, 1'b0, 1'b0, 8'h0, e);
    while (txq.size() > 0) begin
      b = txq.pop_front();
      wait_start(n);
      total++; if (n == 0 || txData !== b) begin bad++;
        $display("FAIL rand_tx_order: got n=%0d data=%h want %h", n, txData, b); end
      tx_done_pulse();
    end
    apb_write(4'hC, 32'h8, 1'b0, 1'b0, 8'h0, e);
    apb_write(4'h8, 32'h30, 1'b0, 1'b0, 8'h0, e);
  endtask

  task automatic test_reset_midbyte();
    logic [31:0] d; logic e; int n; int highs;
    apb_write(4'hC, 32'h1, 1'b0, 1'b0, 8'h0, e);
    apb_write(4'h0, 32'h000000C3, 1'b0, 1'b0, 8'h0, e);
    wait_start(n);
    rst_n = 1'b0; #1;
    total++; if ({txStart, tx_en, txData} !== 10'd0) begin bad++;
      $display("FAIL midbyte_reset: got txStart=%b tx_en=%b txData=%h want 0", txStart, tx_en, txData); end
    @(posedge clk); #1 rst_n = 1'b1;
    highs = 0;
    repeat (10) begin @(negedge clk); if (txStart) highs++; end
    total++; if (highs !== 0) begin bad++;
      $display("FAIL midbyte_no_restart: got %0d starts want 0", highs); end
    apb_read(4'h8, d, e);
    total++; if (d !== 32'h0000_000A) begin bad++;
      $display("FAIL midbyte_status: got %h want 0000000a", d); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_overrun();
    test_frame_err();
    test_flush();
    test_irq();
    test_random();
    test_reset_midbyte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_uart_bridge.md
# apb_uart_bridge

Parametrised APB slave bridging the processor bus to the UART TX/RX cores. It replaces the single-word, four-byte bridge with configurable-depth byte FIFOs in both directions and a small register map (data, status, control). It adds zero-wait APB transfers, error responses, sticky error/overrun flags, flush controls and an interrupt. It sits between the APB interconnect and the UART transmitter/receiver modules.

## Interface
- TX_DEPTH, 16, TX FIFO depth in bytes; power of two, ≥2.
- RX_DEPTH, 16, RX FIFO depth in bytes; power of two, ≥2.
- RX_THRESH, 1, RX fill level (1..RX_DEPTH) that raises the RX interrupt.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- pAdd  in  4  byte address; only [3:2] decoded, [1:0] ignored.
- pwData  in  32  APB write data.
- psel  in  1  slave select.
- pen  in  1  APB enable (access phase).
- pwr  in  1  1 = write, 0 = read.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- txData  out  8  byte to UART TX.
- txStart  out  1  one-cycle start pulse to UART TX.
- txDone  in  1  UART TX finished byte (level, edge-detected).
- busy  in  1  UART TX busy.
- rxData  in  8  received byte.
- rxDone  in  1  UART RX byte ready (level, edge-detected).
- err_in  in  1  UART RX framing error (level, edge-detected).
- tx_en, rx_en  out  1  mirror of CTRL[0], CTRL[1].
- err_out  out  1  sticky framing-error flag (STATUS[5]).
- irq  out  1  interrupt.

## Operation
- Register map (word offsets):
  - 0x0 TXDATA (W): push pwData[7:0] into the TX FIFO.
  - 0x4 RXDATA (R): pop one byte; prdata = {24'b0, byte}.
  - 0x8 STATUS (R; W1C on bits 4 and 5): [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] overrun, [5] frame_err, [6] tx_active, [15:8] tx_count, [23:16] rx_count, other bits 0.
  - 0xC CTRL (R/W): [0] tx_en, [1] rx_en, [2] tx_flush, [3] rx_flush, [4] rx_ie, [5] tx_ie. Flush bits self-clear and always read 0.
- pslverr = 1 with no side effect for: TXDATA write when full, RXDATA read when empty, read of TXDATA, write of RXDATA.
- Push/pop semantics:
  - A push into a full FIFO succeeds only if a pop of the same FIFO occurs in the same cycle; count is then unchanged.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Flush takes precedence over a same-cycle push or pop: count → 0 and pointers reset. The FIFO data array is not cleared.
- TX engine FSM:
  - IDLE → LOAD when tx_en & TX FIFO non-empty & ~busy.
  - LOAD: pop head into txData → START.
  - START: txStart = 1 for exactly one cycle → WAIT.
  - WAIT → IDLE on a txDone rising edge.
  - Clearing tx_en mid-byte does not abort the byte; the FSM finishes WAIT, then stays in IDLE.
  - tx_active = (state ≠ IDLE).
- RX path:
  - On an rxDone rising edge with rx_en = 1, push rxData.
  - If the RX FIFO is full (and there is no same-cycle APB pop), drop the byte and set overrun.
  - When rx_en = 0, rxDone is ignored.
  - An err_in rising edge sets frame_err regardless of rx_en.
  - If a W1C write and a set event hit the same flag in the same cycle, set wins.
- irq = (rx_ie & rx_count ≥ RX_THRESH) | (tx_ie & tx_empty & ~tx_active) | overrun | frame_err.

## Timing
- APB has zero wait states. Setup phase: psel = 1, pen = 0. Access phase: psel = 1, pen = 1.
- pready = psel & pen (combinational). pslverr is valid only while pready = 1, else 0.
- prdata is combinational during a read access phase and 0 at all other times. RXDATA shows the current FIFO head.
- All side effects commit on the clk edge that ends the access phase.
- A pushed byte is visible in the counts on the next cycle.
- TX latency: a TXDATA write with the FSM in IDLE and busy = 0 gives txStart high 2 cycles after the write edge (LOAD, then START).
- Edge detectors on txDone, rxDone and err_in use a one-cycle registered previous value. A level held high counts as one event.
- Reset values:
  - prdata, pslverr, txData, txStart, tx_en, rx_en, err_out and irq are 0.
  - pready = 0 unless psel & pen are already high.
  - FIFOs are empty (tx_empty = rx_empty = 1), CTRL = 0, the FSM is in IDLE, and all edge registers are 0.
- Reset asserted mid-byte returns everything to these values immediately. No txStart is issued after release until a new byte is pushed.

## Test plan
- Reset, then read STATUS → prdata = 0x0000_000A, pslverr = 0.
- Set CTRL = 0x1, write TXDATA 0x55 then 0xAA; pulse txDone after each byte → txStart pulses twice, txData = 0x55 then 0xAA, final STATUS tx_count = 0, tx_empty = 1.
- Fill TX with 16 bytes while tx_en = 0; the 17th write → pslverr = 1, tx_count = 16, byte dropped.
- rx_en = 1, deliver 17 rxDone edges (bytes 0x00..0x10) → rx_count = 16, overrun = 1, irq = 1. Sixteen RXDATA reads return 0x00..0x0F; the 17th read → pslverr = 1, prdata = 0.
- Pulse err_in → err_out = 1. Write STATUS 0x20 → err_out = 0. An err_in edge in the same cycle as the W1C keeps err_out = 1.
- Write CTRL 0x8 with 5 bytes in the RX FIFO and an rxDone edge in the same cycle → rx_count = 0, CTRL reads back 0.
